// File: rtl/pool_pkg.sv
// Shared types and width helper for the streaming KxK pooling engine.
// Max pooling is compiled in only when POOL_MAX_EN is defined.
package pool_pkg;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pool_state_e;

  // Each window sums K*K pixels, so 2*log2(K) guard bits prevent overflow.
  function automatic int acc_width(input int data_w, input int k);
    return data_w + 2 * $clog2(k);
  endfunction

endpackage

// File: rtl/pool_acc_bank.sv
// Per-column-window accumulator array: combinational read, single write port,
// and a bulk clear used at frame start.
module pool_acc_bank
  import pool_pkg::*;
#(
  parameter int N  = 14,
  parameter int W  = 18,
  parameter int IW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_all,
  input  logic                wr_en,
  input  logic [IW-1:0]       idx,
  input  logic signed [W-1:0] wr_data,
  output logic signed [W-1:0] rd_data
);

  logic signed [W-1:0] acc [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) acc[i] <= '0;
    end else if (clear_all) begin
      for (int i = 0; i < N; i++) acc[i] <= '0;
    end else if (wr_en) begin
      acc[idx] <= wr_data;
    end
  end

  assign rd_data = acc[idx];

endmodule

// File: rtl/pool_stream_kxk.sv
// Streaming KxK non-overlapping pooling engine (average always, max when
// POOL_MAX_EN is defined) over valid/ready input and output streams.
module pool_stream_kxk
  import pool_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 2,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     busy,
  output logic                     done
);

  localparam int KL    = $clog2(K);
  localparam int SH    = 2 * KL;
  localparam int ACC_W = acc_width(DATA_W, K);
  localparam int N     = IMG_W / K;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  pool_state_e state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_loaded;
  logic          accept, out_fire, frame_start;
  logic          win_first, win_last, frame_last;
  logic [IW-1:0] idx;
  logic signed [ACC_W-1:0] pix, acc_rd, acc_new, acc_wr, result;

  assign in_ready    = (state == RUN) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign frame_start = (state == IDLE) && start;
  assign busy        = (state == RUN);
  assign done        = (state == DONE);

  assign win_first  = (row[KL-1:0] == '0) && (col[KL-1:0] == '0);
  assign win_last   = (&row[KL-1:0]) && (&col[KL-1:0]);
  assign frame_last = (row == ROW_LAST) && (col == COL_LAST);
  assign idx        = IW'(col >> KL);
  assign pix        = ACC_W'(in_data);

`ifdef POOL_MAX_EN
  pool_mode_e mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= POOL_AVG;
    else if (frame_start) mode_q <= pool_mode_e'(mode);
  end

  // The first pixel of a window loads the entry so stale values never win the compare.
  always_comb begin
    acc_new = acc_rd + pix;
    result  = acc_new >>> SH;
    if (mode_q == POOL_MAX) begin
      acc_new = (win_first || (pix > acc_rd)) ? pix : acc_rd;
      result  = acc_new;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign acc_new = acc_rd + pix;
  assign result  = acc_new >>> SH;
`endif

  assign acc_wr = win_last ? '0 : acc_new;

  pool_acc_bank #(.N(N), .W(ACC_W), .IW(IW)) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_all(frame_start),
    .wr_en    (accept),
    .idx      (idx),
    .wr_data  (acc_wr),
    .rd_data  (acc_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (out_fire && last_loaded) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col         <= '0;
      row         <= '0;
      last_loaded <= 1'b0;
    end else if (frame_start) begin
      col         <= '0;
      row         <= '0;
      last_loaded <= 1'b0;
    end else if (accept) begin
      if (win_last && frame_last) last_loaded <= 1'b1;
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // A completing window may reload the register in the same cycle it is drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept && win_last) begin
      out_valid <= 1'b1;
      out_data  <= OUT_W'(result);
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool_stream_kxk.sv
// Directed testbench for pool_stream_kxk on a 4x4 map with K=2; the max
// pooling frame runs only when POOL_MAX_EN is defined.
module tb_pool_stream_kxk;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int K      = 2;
  localparam int DATA_W = 16;
  localparam int OUT_W  = 14;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NOUT   = NPIX / (K * K);
  localparam int MASK   = (1 << OUT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [DATA_W-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;
  logic busy;
  logic done;

  int errors = 0;
  int checks = 0;
  int pix [NPIX];
  int exp_v [NOUT];
  int got [$];
  int done_cnt = 0;

  always #5 clk = ~clk;

  pool_stream_kxk #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DATA_W(DATA_W), .OUT_W(OUT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .done     (done)
  );

  always @(negedge clk) if (done) done_cnt++;

  task automatic check_output(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic fill_raster();
    for (int i = 0; i < NPIX; i++) pix[i] = i;
  endtask

  task automatic pulse_start(input logic m);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Presents each pixel until accepted; optional idle gap and a stray start pulse.
  task automatic drive_pixels(input int gap, input int mid_start, input int count);
    for (int i = 0; i < count; i++) begin
      bit ok;
      int t;
      in_valid = 1'b1;
      in_data  = DATA_W'(pix[i]);
      if (i == mid_start) start = 1'b1;
      ok = 1'b0;
      t  = 0;
      while (!ok && t < 50) begin
        @(negedge clk); #2;
        ok = in_ready;
        @(posedge clk); #1;
        t++;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      if (!ok) check_output("in_ready_timeout", 0, 1);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Drains outputs until done; holds off the first output for 'stall' cycles.
  task automatic collect(input int stall, input string tag);
    int stall_left;
    bit first;
    bit fin;
    logic [OUT_W-1:0] held;
    stall_left = stall;
    first = 1'b1;
    fin   = 1'b0;
    held  = '0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        #1;
        if (first) begin
          held  = out_data;
          first = 1'b0;
        end else begin
          check_output({tag, "_hold_data"}, int'(out_data), int'(held));
        end
        check_output({tag, "_stall_in_ready"}, int'(in_ready), 0);
        stall_left--;
      end else begin
        out_ready = 1'b1;
        #1;
        if (out_valid) got.push_back(int'(out_data));
      end
      if (done) begin
        fin = 1'b1;
        check_output({tag, "_busy_at_done"}, int'(busy), 0);
      end
    end
    if (!fin) check_output({tag, "_done_timeout"}, 0, 1);
    out_ready = 1'b1;
  endtask

  task automatic apply_stimulus(input string tag, input logic m, input int gap,
                                input int stall, input int mid_start);
    int base;
    got.delete();
    base = done_cnt;
    pulse_start(m);
    check_output({tag, "_busy"}, int'(busy), 1);
    fork
      drive_pixels(gap, mid_start, NPIX);
      collect(stall, tag);
    join
    repeat (3) @(posedge clk);
    #1;
    check_output({tag, "_count"}, got.size(), NOUT);
    for (int i = 0; i < NOUT; i++)
      check_output($sformatf("%s_out%0d", tag, i),
                   (i < got.size()) ? got[i] : -1, exp_v[i] & MASK);
    check_output({tag, "_done_pulses"}, done_cnt - base, 1);
  endtask

  initial begin
    #12;
    check_output("reset_in_ready", int'(in_ready), 0);
    check_output("reset_out_valid", int'(out_valid), 0);
    check_output("reset_out_data", int'(out_data), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    fill_raster();
    exp_v = '{2, 4, 10, 12};
    apply_stimulus("avg_raster", 1'b0, 0, 0, -1);

`ifdef POOL_MAX_EN
    exp_v = '{5, 7, 13, 15};
    apply_stimulus("max_raster", 1'b1, 0, 0, -1);
`endif

    for (int i = 0; i < NPIX; i++) pix[i] = 0;
    pix[0] = -1;
    pix[1] = -2;
    pix[4] = -3;
    pix[5] = -4;
    exp_v = '{-3, 0, 0, 0};
    apply_stimulus("avg_negative", 1'b0, 0, 0, -1);

    fill_raster();
    exp_v = '{2, 4, 10, 12};
    apply_stimulus("backpressure", 1'b0, 0, 3, -1);

    apply_stimulus("mid_start", 1'b0, 0, 0, 3);

    pulse_start(1'b0);
    drive_pixels(0, -1, 7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("midreset_out_valid", int'(out_valid), 0);
    check_output("midreset_out_data", int'(out_data), 0);
    check_output("midreset_busy", int'(busy), 0);
    check_output("midreset_in_ready", int'(in_ready), 0);
    check_output("midreset_done", int'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    apply_stimulus("after_reset", 1'b0, 0, 0, -1);

    apply_stimulus("valid_toggle", 1'b0, 1, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
